// File: rtl/al_pkg.sv
// al_time_set shared types, limits and default timing.
// BCD helpers wrap out-of-range seeds to 00 on the next increment.
package al_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    COMMIT   = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] ms;
    logic [3:0] ls;
  } bcd2_t;

  localparam logic [3:0] HOUR_MS_MAX = 4'd2;
  localparam logic [3:0] HOUR_LS_MAX = 4'd3;
  localparam logic [3:0] MIN_MS_MAX  = 4'd5;
  localparam logic [3:0] MIN_LS_MAX  = 4'd9;

  localparam int DEBOUNCE_SYN = 250000;
  localparam int REPEAT_SYN   = 6250000;
  localparam int BLINK_SYN    = 6250000;
  localparam int DEBOUNCE_SIM = 4;
  localparam int REPEAT_SIM   = 16;
  localparam int BLINK_SIM    = 8;

  function automatic bcd2_t inc_hour(bcd2_t v);
    bcd2_t r;
    r = '0;
    if (v.ms > HOUR_MS_MAX || v.ls > 4'd9 ||
        (v.ms == HOUR_MS_MAX && v.ls >= HOUR_LS_MAX)) begin
      r = '0;
    end else if (v.ls == 4'd9) begin
      r.ms = v.ms + 4'd1;
      r.ls = 4'd0;
    end else begin
      r.ms = v.ms;
      r.ls = v.ls + 4'd1;
    end
    return r;
  endfunction

  function automatic bcd2_t inc_min(bcd2_t v);
    bcd2_t r;
    r = '0;
    if (v.ms > MIN_MS_MAX || v.ls > MIN_LS_MAX ||
        (v.ms == MIN_MS_MAX && v.ls == MIN_LS_MAX)) begin
      r = '0;
    end else if (v.ls == 4'd9) begin
      r.ms = v.ms + 4'd1;
      r.ls = 4'd0;
    end else begin
      r.ms = v.ms;
      r.ls = v.ls + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/al_btn_debounce.sv
// Push-button front end: 2-flop sync, debounce counter, rising-edge pulse.
// level moves only after the synced input differs for DEBOUNCE_CYCLES cycles.
module al_btn_debounce
  import al_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
  input  logic mclk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      s1      <= raw;
      s2      <= s1;
      level_q <= level;
      if (s2 != level) begin
        if (cnt == LAST) begin
          level <= s2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign press = level & ~level_q;

endmodule

// File: rtl/al_time_set.sv
// Alarm clock time-setting FSM: edits a working BCD copy, commits with load.
// Also drives hold for the clock and the blink mask for the display.
module al_time_set
  import al_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_SYN,
  parameter int REPEAT_CYCLES   = REPEAT_SYN,
  parameter int BLINK_CYCLES    = BLINK_SYN
) (
  input  logic       mclk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] cur_ms_hour,
  input  logic [3:0] cur_ls_hour,
  input  logic [3:0] cur_ms_min,
  input  logic [3:0] cur_ls_min,
  output logic [3:0] set_ms_hour,
  output logic [3:0] set_ls_hour,
  output logic [3:0] set_ms_min,
  output logic [3:0] set_ls_min,
  output logic       load,
  output logic       hold,
  output logic [3:0] blink_mask
);

  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  localparam logic [RW-1:0] RLAST = RW'(REPEAT_CYCLES - 1);
  localparam logic [BW-1:0] BLAST = BW'(BLINK_CYCLES - 1);

  state_t        state;
  state_t        state_n;
  logic          mode_press;
  logic          mode_level;
  logic          inc_press;
  logic          inc_level;
  logic          in_set;
  logic          rep_fire;
  logic          inc_evt;
  logic [RW-1:0] rep_cnt;
  logic [BW-1:0] blink_cnt;
  logic          phase_off;
  bcd2_t         hr;
  bcd2_t         mn;

  al_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .mclk  (mclk),
    .rst_n (rst_n),
    .raw   (btn_mode),
    .level (mode_level),
    .press (mode_press)
  );

  al_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .mclk  (mclk),
    .rst_n (rst_n),
    .raw   (btn_inc),
    .level (inc_level),
    .press (inc_press)
  );

  assign in_set   = (state == SET_HOUR) || (state == SET_MIN);
  assign rep_fire = in_set & inc_level & ~inc_press & (rep_cnt == RLAST);
  // mode wins over a same-cycle increment
  assign inc_evt  = in_set & (inc_press | rep_fire) & ~mode_press;

  always_ff @(posedge mclk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      RUN:      if (mode_press) state_n = SET_HOUR;
      SET_HOUR: if (mode_press) state_n = SET_MIN;
      SET_MIN:  if (mode_press) state_n = COMMIT;
      COMMIT:   state_n = RUN;
      default:  state_n = RUN;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      hr <= '0;
      mn <= '0;
    end else if (state == RUN && mode_press) begin
      hr <= {cur_ms_hour, cur_ls_hour};
      mn <= {cur_ms_min, cur_ls_min};
    end else if (inc_evt) begin
      if (state == SET_HOUR) hr <= inc_hour(hr);
      else                   mn <= inc_min(mn);
    end
  end

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      rep_cnt <= '0;
    end else if (!in_set || !inc_level || inc_press ||
                 state_n != state || rep_fire) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + RW'(1);
    end
  end

  // restart in the on phase so freshly edited digits show at once
  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase_off <= 1'b0;
    end else if (!in_set || state_n != state || inc_evt) begin
      blink_cnt <= '0;
      phase_off <= 1'b0;
    end else if (blink_cnt == BLAST) begin
      blink_cnt <= '0;
      phase_off <= ~phase_off;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  always_comb begin
    blink_mask = 4'b1111;
    unique case (1'b1)
      phase_off && state == SET_HOUR: blink_mask = 4'b0011;
      phase_off && state == SET_MIN:  blink_mask = 4'b1100;
      default:                        blink_mask = 4'b1111;
    endcase
  end

  assign hold        = (state != RUN);
  assign load        = (state == COMMIT);
  assign set_ms_hour = hr.ms;
  assign set_ls_hour = hr.ls;
  assign set_ms_min  = mn.ms;
  assign set_ls_min  = mn.ls;

endmodule
